udp_tx_scheduler: RTL and testbench

//  Shares one UDP transmit engine between N_REQ packet sources using round-robin arbitration.

---
 rtl/udp_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_udp_tx_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | udp_tx_scheduler                                                         |
// | Round-robin sharing of one UDP transmit engine among N_REQ sources.      |
// | Optional WAIT watchdog: define UDP_TX_SCHED_TIMEOUT_EN.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module udp_tx_scheduler #(
   parameter int N_REQ       = 2,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_i,
   input  logic [16*N_REQ-1:0]   length_i,
   input  logic [32*N_REQ-1:0]   remote_ip_i,
   input  logic [16*N_REQ-1:0]   remote_port_i,
   input  logic [16*N_REQ-1:0]   local_port_i,
   input  logic                  tx_done_i,
   output logic [N_REQ-1:0]      grant_o,
   output logic [N_REQ-1:0]      done_o,
   output logic                  udp_sendpacket,
   output logic [15:0]           length_o,
   output logic [31:0]           remote_IP_o,
   output logic [15:0]           remote_port_o,
   output logic [15:0]           local_port_o,
   output logic                  busy_o,
   output logic                  timeout_o
);

   localparam int c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_START = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_param_check
      $error("udp_tx_scheduler: parameter out of range");
   end

   logic [1:0]          r_state;
   logic [N_REQ-1:0]    r_grant;
   logic [c_PTR_W-1:0]  r_grant_idx;
   logic [c_PTR_W-1:0]  r_rr_ptr;
   logic [15:0]         r_length;
   logic [31:0]         r_remote_ip;
   logic [15:0]         r_remote_port;
   logic [15:0]         r_local_port;

   logic                w_any_req;
   logic [c_PTR_W-1:0]  w_win_idx;

   // Modulo-N_REQ wrap for values in [0, 2*N_REQ-1]; N_REQ need not be a power of two.
   function automatic logic [c_PTR_W-1:0] f_wrap(input int v);
      return (v >= N_REQ) ? c_PTR_W'(v - N_REQ) : c_PTR_W'(v);
   endfunction

   // Scan downward so the last hit, i.e. the nearest set bit at or above rr_ptr, wins.
   always_comb begin
      w_any_req = |req_i;
      w_win_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_i[f_wrap(int'(r_rr_ptr) + i)]) begin
            w_win_idx = f_wrap(int'(r_rr_ptr) + i);
         end
      end
   end

`ifdef UDP_TX_SCHED_TIMEOUT_EN
   localparam logic [15:0] c_WDOG_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0] r_wdog;
   logic        r_timeout;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= c_IDLE;
         r_grant       <= '0;
         r_grant_idx   <= '0;
         r_rr_ptr      <= '0;
         r_length      <= '0;
         r_remote_ip   <= '0;
         r_remote_port <= '0;
         r_local_port  <= '0;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
         r_wdog        <= '0;
         r_timeout     <= 1'b0;
`endif
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_any_req) begin
                  r_grant       <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx;
                  r_grant_idx   <= w_win_idx;
                  r_length      <= length_i     [int'(w_win_idx)*16 +: 16];
                  r_remote_ip   <= remote_ip_i  [int'(w_win_idx)*32 +: 32];
                  r_remote_port <= remote_port_i[int'(w_win_idx)*16 +: 16];
                  r_local_port  <= local_port_i [int'(w_win_idx)*16 +: 16];
                  r_state       <= c_START;
               end
            end
            c_START: begin
               // Zero-length descriptors never reach the engine.
               r_state <= (r_length == 16'd0) ? c_DONE : c_WAIT;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
               r_wdog  <= '0;
`endif
            end
            c_WAIT: begin
               if (tx_done_i) begin
                  r_state <= c_DONE;
               end
`ifdef UDP_TX_SCHED_TIMEOUT_EN
               else if (r_wdog == c_WDOG_LAST) begin
                  r_state   <= c_DONE;
                  r_timeout <= 1'b1;
               end else begin
                  r_wdog <= r_wdog + 16'd1;
               end
`endif
            end
            c_DONE: begin
               r_grant  <= '0;
               r_rr_ptr <= f_wrap(int'(r_grant_idx) + 1);
               r_state  <= c_IDLE;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
               r_timeout <= 1'b0;
`endif
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign grant_o        = r_grant;
   assign done_o         = (r_state == c_DONE) ? r_grant : '0;
   assign udp_sendpacket = (r_state == c_START) && (r_length != 16'd0);
   assign busy_o         = (r_state != c_IDLE);
   assign length_o       = r_length;
   assign remote_IP_o    = r_remote_ip;
   assign remote_port_o  = r_remote_port;
   assign local_port_o   = r_local_port;

`ifdef UDP_TX_SCHED_TIMEOUT_EN
   assign timeout_o = (r_state == c_DONE) && r_timeout;
`else
   assign timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_udp_tx_scheduler                                                      |
// | Scoreboard bench for udp_tx_scheduler (N_REQ=2, TIMEOUT_CYC=16).         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_udp_tx_scheduler;

   typedef struct packed {
      logic [1:0]  grant;
      logic [15:0] len;
      logic [31:0] ip;
      logic [15:0] rport;
      logic [15:0] lport;
      logic        tmo;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req_i = 2'b00;
   logic        tx_done_i = 1'b0;
   logic [15:0] len_a [2];
   logic [31:0] ip_a  [2];
   logic [15:0] rp_a  [2];
   logic [15:0] lp_a  [2];

   logic [31:0] length_i, remote_port_i, local_port_i;
   logic [63:0] remote_ip_i;
   logic [1:0]  grant_o, done_o;
   logic        udp_sendpacket, busy_o, timeout_o;
   logic [15:0] length_o, remote_port_o, local_port_o;
   logic [31:0] remote_IP_o;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   n_strobe = 0;
   int   s0;

   assign length_i      = {len_a[1], len_a[0]};
   assign remote_ip_i   = {ip_a[1],  ip_a[0]};
   assign remote_port_i = {rp_a[1],  rp_a[0]};
   assign local_port_i  = {lp_a[1],  lp_a[0]};

   udp_tx_scheduler #(.N_REQ(2), .TIMEOUT_CYC(16)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .req_i          (req_i),
      .length_i       (length_i),
      .remote_ip_i    (remote_ip_i),
      .remote_port_i  (remote_port_i),
      .local_port_i   (local_port_i),
      .tx_done_i      (tx_done_i),
      .grant_o        (grant_o),
      .done_o         (done_o),
      .udp_sendpacket (udp_sendpacket),
      .length_o       (length_o),
      .remote_IP_o    (remote_IP_o),
      .remote_port_o  (remote_port_o),
      .local_port_o   (local_port_o),
      .busy_o         (busy_o),
      .timeout_o      (timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pkt(input int src, input logic tmo);
      exp_t e;
      e.grant = 2'b01 << src;
      e.len   = len_a[src];
      e.ip    = ip_a[src];
      e.rport = rp_a[src];
      e.lport = lp_a[src];
      e.tmo   = tmo;
      sb.push_back(e);
   endtask

   // Called in the START cycle; returns in the DONE cycle.
   task automatic engine_done(input int cyc);
      repeat (cyc - 1) tick();
      tx_done_i = 1'b1;
      tick();
      tx_done_i = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_grant"}, grant_o, 0);
      chk({tag, "_done"},  done_o, 0);
      chk({tag, "_strobe"}, udp_sendpacket, 0);
      chk({tag, "_busy"},  busy_o, 0);
      chk({tag, "_tmo"},   timeout_o, 0);
      chk({tag, "_len"},   length_o, 0);
      chk({tag, "_ip"},    remote_IP_o, 0);
      chk({tag, "_rport"}, remote_port_o, 0);
      chk({tag, "_lport"}, local_port_o, 0);
   endtask

   // Output-side scoreboard: strobe peeks the head entry, done_o retires it.
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (udp_sendpacket) begin
         n_strobe++;
         if (sb.size() == 0) chk("strobe_unexpected", 1, 0);
         else chk("strobe_len", length_o, sb[0].len);
      end
      if (done_o != 2'b00) begin
         if (sb.size() == 0) begin
            chk("done_unexpected", done_o, 0);
         end else begin
            e = sb.pop_front();
            chk("sb_done",  done_o,        e.grant);
            chk("sb_grant", grant_o,       e.grant);
            chk("sb_len",   length_o,      e.len);
            chk("sb_ip",    remote_IP_o,   e.ip);
            chk("sb_rport", remote_port_o, e.rport);
            chk("sb_lport", local_port_o,  e.lport);
            chk("sb_tmo",   timeout_o,     e.tmo);
         end
      end
   end

   initial begin
      len_a[0] = 16'd100; ip_a[0] = 32'hC0A80005; rp_a[0] = 16'd5000; lp_a[0] = 16'd6000;
      len_a[1] = 16'd200; ip_a[1] = 32'h0A000001; rp_a[1] = 16'd7000; lp_a[1] = 16'd8000;

      repeat (2) tick();
      chk_quiet("rst");
      reset = 1'b0;
      tick();

      // T1: single packet from source 0
      req_i = 2'b01;
      expect_pkt(0, 1'b0);
      tick();
      chk("t1_grant",  grant_o, 2'b01);
      chk("t1_strobe", udp_sendpacket, 1);
      chk("t1_ip",     remote_IP_o, 32'hC0A80005);
      tick();
      chk("t1_strobe_once", udp_sendpacket, 0);
      engine_done(9);
      chk("t1_done", done_o, 2'b01);
      req_i = 2'b00;
      tick();
      chk("t1_idle_busy", busy_o, 0);
      chk("t1_done_pulse", done_o, 0);
      chk("t1_strobes", n_strobe, 1);

      // T2: both sources requesting continuously
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      s0 = n_strobe;
      req_i = 2'b11;
      for (int k = 0; k < 6; k++) begin
         expect_pkt(k % 2, 1'b0);
         tick();
         chk("t2_grant", grant_o, 2'b01 << (k % 2));
         chk("t2_strobe", udp_sendpacket, 1);
         engine_done(3);
         chk("t2_done", done_o, 2'b01 << (k % 2));
         if (k == 5) req_i = 2'b00;
         tick();
         chk("t2_gap_busy", busy_o, 0);
      end
      chk("t2_strobes", n_strobe - s0, 6);

      // T3: zero-length descriptor bypasses the engine
      len_a[0] = 16'd0;
      s0 = n_strobe;
      req_i = 2'b01;
      expect_pkt(0, 1'b0);
      tick();
      chk("t3_grant", grant_o, 2'b01);
      chk("t3_nostrobe", udp_sendpacket, 0);
      tick();
      chk("t3_done", done_o, 2'b01);
      req_i = 2'b00;
      tick();
      chk("t3_busy", busy_o, 0);
      chk("t3_strobes", n_strobe - s0, 0);

      // T4: spurious tx_done in IDLE/START, req dropped and descriptors changed in WAIT
      len_a[0] = 16'd40;
      tx_done_i = 1'b1;
      tick();
      tx_done_i = 1'b0;
      chk("t4_idle_busy", busy_o, 0);
      chk("t4_idle_done", done_o, 0);
      req_i = 2'b10;
      expect_pkt(1, 1'b0);
      tick();
      chk("t4_grant", grant_o, 2'b10);
      tx_done_i = 1'b1;
      tick();
      tx_done_i = 1'b0;
      chk("t4_start_done", done_o, 0);
      chk("t4_wait_busy", busy_o, 1);
      req_i = 2'b00;
      len_a[1] = 16'hFFFF;
      ip_a[1]  = 32'h0;
      engine_done(4);
      chk("t4_done", done_o, 2'b10);
      chk("t4_len_held", length_o, 16'd200);
      tick();
      chk("t4_busy", busy_o, 0);
      len_a[1] = 16'd200;
      ip_a[1]  = 32'h0A000001;

      // T5: reset while waiting on the engine
      req_i = 2'b01;
      expect_pkt(0, 1'b0);
      tick();
      tick();
      chk("t5_wait_busy", busy_o, 1);
      reset = 1'b1;
      req_i = 2'b00;
      void'(sb.pop_front());
      tick();
      chk_quiet("t5_rst");
      tick();
      reset = 1'b0;
      req_i = 2'b10;
      expect_pkt(1, 1'b0);
      tick();
      chk("t5_grant", grant_o, 2'b10);
      engine_done(2);
      chk("t5_done", done_o, 2'b10);
      req_i = 2'b00;
      tick();

`ifdef UDP_TX_SCHED_TIMEOUT_EN
      // T6: watchdog expiry, then tx_done arriving on the final WAIT cycle
      req_i = 2'b01;
      expect_pkt(0, 1'b1);
      tick();
      tick();
      repeat (15) tick();
      chk("t6_early", done_o, 0);
      tick();
      chk("t6_tmo_done", done_o, 2'b01);
      chk("t6_tmo", timeout_o, 1);
      req_i = 2'b00;
      tick();
      req_i = 2'b01;
      expect_pkt(0, 1'b0);
      tick();
      tick();
      repeat (15) tick();
      tx_done_i = 1'b1;
      tick();
      tx_done_i = 1'b0;
      chk("t6_race_done", done_o, 2'b01);
      chk("t6_race_tmo", timeout_o, 0);
      req_i = 2'b00;
      tick();
`else
      chk("t6_tmo_tied", timeout_o, 0);
`endif

      tick();
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
